// File: rtl/axi_sram_slave.sv
// AXI4 slave that serves one burst at a time from a single-port synchronous 64-bit SRAM.
// Reads win over writes; FIXED bursts hold the address, all other burst types increment it.
module axi_sram_slave #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // read address
  input  logic                        mem_axi_ar_valid_i,
  output logic                        mem_axi_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   mem_axi_ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     mem_axi_ar_id_i,
  input  logic [7:0]                  mem_axi_ar_len_i,
  input  logic [2:0]                  mem_axi_ar_size_i,
  input  logic [1:0]                  mem_axi_ar_burst_i,
  // read data
  output logic                        mem_axi_r_valid_o,
  input  logic                        mem_axi_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   mem_axi_r_data_o,
  output logic [1:0]                  mem_axi_r_resp_o,
  output logic                        mem_axi_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]     mem_axi_r_id_o,
  // write address
  input  logic                        mem_axi_aw_valid_i,
  output logic                        mem_axi_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   mem_axi_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     mem_axi_aw_id_i,
  input  logic [7:0]                  mem_axi_aw_len_i,
  input  logic [2:0]                  mem_axi_aw_size_i,
  input  logic [1:0]                  mem_axi_aw_burst_i,
  // write data
  input  logic                        mem_axi_w_valid_i,
  output logic                        mem_axi_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] mem_axi_w_strb_i,
  input  logic                        mem_axi_w_last_i,
  // write response
  output logic                        mem_axi_b_valid_o,
  input  logic                        mem_axi_b_ready_i,
  output logic [1:0]                  mem_axi_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     mem_axi_b_id_o,
  // SRAM
  output logic                        sram_en,
  output logic [7:0]                  sram_we,
  output logic [MEM_ADDR_WIDTH-1:0]   sram_addr,
  output logic [63:0]                 sram_wdata,
  input  logic [63:0]                 sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_LAT, S_RD_RESP, S_WR_DATA, S_WR_RESP
  } state_t;

  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                  r_len;
  logic [7:0]                  r_cnt;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic                        r_err;
  logic [AXI_ID_WIDTH-1:0]     r_rid;
  logic [AXI_ID_WIDTH-1:0]     r_bid;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic                        r_rvalid;
  logic                        r_rlast;
  logic [1:0]                  r_rresp;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;

  logic                        w_is_last;
  logic                        w_last_bad;
  logic                        w_wr_beat;
  logic [AXI_ADDR_WIDTH-1:0]   w_addr_next;

  assign w_is_last   = (r_cnt == r_len);
  assign w_last_bad  = (mem_axi_w_last_i != w_is_last);
  assign w_wr_beat   = (r_state == S_WR_DATA) && mem_axi_w_valid_i;
  // FIXED keeps the address; INCR, WRAP and reserved all step by the beat size.
  assign w_addr_next = (r_burst == 2'b00) ? r_addr
                                          : r_addr + (AXI_ADDR_WIDTH'(1) << r_size);

  assign mem_axi_ar_ready_o = rst_n && (r_state == S_IDLE);
  assign mem_axi_aw_ready_o = rst_n && (r_state == S_IDLE) && !mem_axi_ar_valid_i;
  assign mem_axi_w_ready_o  = rst_n && (r_state == S_WR_DATA);

  assign mem_axi_r_valid_o = r_rvalid;
  assign mem_axi_r_data_o  = r_rdata;
  assign mem_axi_r_resp_o  = r_rresp;
  assign mem_axi_r_last_o  = r_rlast;
  assign mem_axi_r_id_o    = r_rid;
  assign mem_axi_b_valid_o = r_bvalid;
  assign mem_axi_b_resp_o  = r_bresp;
  assign mem_axi_b_id_o    = r_bid;

  assign sram_addr  = r_addr[MEM_ADDR_WIDTH+2:3];
  assign sram_wdata = mem_axi_w_data_i;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    sram_en = 1'b0;
    sram_we = 8'h00;
    case (r_state)
      S_RD_REQ:  sram_en = !r_err;
      S_WR_DATA: begin
        sram_en = w_wr_beat;
        sram_we = (w_wr_beat && !r_err) ? mem_axi_w_strb_i : 8'h00;
      end
      default: ;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_err    <= 1'b0;
      r_rid    <= '0;
      r_bid    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= 2'b00;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_axi_ar_valid_i) begin
            r_addr  <= mem_axi_ar_addr_i;
            r_len   <= mem_axi_ar_len_i;
            r_size  <= mem_axi_ar_size_i;
            r_burst <= mem_axi_ar_burst_i;
            r_rid   <= mem_axi_ar_id_i;
            r_err   <= (mem_axi_ar_size_i > 3'd3);
            r_cnt   <= '0;
            r_state <= S_RD_REQ;
          end else if (mem_axi_aw_valid_i) begin
            r_addr  <= mem_axi_aw_addr_i;
            r_len   <= mem_axi_aw_len_i;
            r_size  <= mem_axi_aw_size_i;
            r_burst <= mem_axi_aw_burst_i;
            r_bid   <= mem_axi_aw_id_i;
            r_err   <= (mem_axi_aw_size_i > 3'd3);
            r_cnt   <= '0;
            r_state <= S_WR_DATA;
          end
        end
        S_RD_REQ: r_state <= S_RD_LAT;
        S_RD_LAT: begin
          r_rdata  <= r_err ? '0 : sram_rdata;
          r_rresp  <= r_err ? 2'b10 : 2'b00;
          r_rlast  <= w_is_last;
          r_rvalid <= 1'b1;
          r_state  <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (mem_axi_r_ready_i) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= w_addr_next;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_WR_DATA: begin
          if (mem_axi_w_valid_i) begin
            r_addr <= w_addr_next;
            r_cnt  <= r_cnt + 8'd1;
            if (w_last_bad) r_err <= 1'b1;
            // The beat count, not w_last, decides when the burst ends.
            if (w_is_last) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || w_last_bad) ? 2'b10 : 2'b00;
              r_state  <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: begin
          if (mem_axi_b_ready_i) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a transaction-level model predicts R beats, SRAM writes
// and B responses, and one negedge process compares them against the DUT.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id, r_id, b_id;
  logic [7:0]  ar_len, aw_len, w_strb, sram_we;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
  logic        r_valid, r_ready, r_last, b_valid, b_ready, sram_en;
  logic [63:0] r_data, w_data, sram_wdata, sram_rdata;
  logic [15:0] sram_addr;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .mem_axi_ar_valid_i(ar_valid), .mem_axi_ar_ready_o(ar_ready),
    .mem_axi_ar_addr_i(ar_addr), .mem_axi_ar_id_i(ar_id), .mem_axi_ar_len_i(ar_len),
    .mem_axi_ar_size_i(ar_size), .mem_axi_ar_burst_i(ar_burst),
    .mem_axi_r_valid_o(r_valid), .mem_axi_r_ready_i(r_ready), .mem_axi_r_data_o(r_data),
    .mem_axi_r_resp_o(r_resp), .mem_axi_r_last_o(r_last), .mem_axi_r_id_o(r_id),
    .mem_axi_aw_valid_i(aw_valid), .mem_axi_aw_ready_o(aw_ready),
    .mem_axi_aw_addr_i(aw_addr), .mem_axi_aw_id_i(aw_id), .mem_axi_aw_len_i(aw_len),
    .mem_axi_aw_size_i(aw_size), .mem_axi_aw_burst_i(aw_burst),
    .mem_axi_w_valid_i(w_valid), .mem_axi_w_ready_o(w_ready), .mem_axi_w_data_i(w_data),
    .mem_axi_w_strb_i(w_strb), .mem_axi_w_last_i(w_last),
    .mem_axi_b_valid_o(b_valid), .mem_axi_b_ready_i(b_ready), .mem_axi_b_resp_o(b_resp),
    .mem_axi_b_id_o(b_id),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Synchronous SRAM: read data appears one cycle after an enabled read.
  logic [63:0] mem     [0:65535];
  logic [63:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 8'h00) sram_rdata <= mem[sram_addr];
      else for (int b = 0; b < 8; b++)
        if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
  typedef struct { logic [15:0] idx; logic [7:0] we; logic [63:0] data; } wbeat_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bresp_t;
  rbeat_t exp_r[$];
  wbeat_t exp_w[$];
  bresp_t exp_b[$];

  logic [63:0] wd [0:7];
  logic [7:0]  ws [0:7];
  logic        wl [0:7];
  logic        no_sram = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  task automatic preload(input logic [15:0] idx, input logic [63:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    bit err;
    a = addr;
    err = (size > 3'd3);
    for (int i = 0; i <= int'(len); i++) begin
      rbeat_t b;
      b.data = err ? 64'd0 : ref_mem[a[18:3]];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      b.id   = id;
      exp_r.push_back(b);
      a = next_addr(a, size, burst);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    bit err;
    bresp_t br;
    a = addr;
    err = (size > 3'd3);
    for (int i = 0; i <= int'(len); i++) begin
      wbeat_t w;
      w.idx  = a[18:3];
      w.we   = err ? 8'h00 : ws[i];
      w.data = wd[i];
      exp_w.push_back(w);
      if (!err)
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) ref_mem[a[18:3]][b*8 +: 8] = wd[i][b*8 +: 8];
      if (wl[i] != (i == int'(len))) err = 1'b1;
      a = next_addr(a, size, burst);
    end
    br.resp = err ? 2'b10 : 2'b00;
    br.id   = id;
    exp_b.push_back(br);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    model_read(addr, id, len, size, burst);
    ar_addr = addr; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ar_ready && t < 50);
    check("ar_ready", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!aw_ready && t < 50);
    check("aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic recv_r(input int nbeats, input int stall_beat, input int stall_n,
                        output int first_cyc, output logic [63:0] d,
                        output logic [1:0] rs, output logic [3:0] id);
    int cyc, beat, stalled;
    cyc = 0; beat = 0; stalled = 0; first_cyc = -1;
    d = '0; rs = '0; id = '0;
    while (beat < nbeats && cyc < 200) begin
      r_ready = !(beat == stall_beat && stalled < stall_n);
      @(negedge clk);
      cyc++;
      if (r_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (r_ready) begin
          beat++;
          d = r_data; rs = r_resp; id = r_id;
        end else stalled++;
      end
      @(posedge clk); #1;
    end
    r_ready = 1'b0;
    check("r_beat_count", 64'(beat), 64'(nbeats));
  endtask

  task automatic write_beats(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = wl[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!w_ready && t < 50);
      check("w_ready", 64'(w_ready), 64'd1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] rs, output logic [3:0] id);
    int t;
    b_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!b_valid && t < 50);
    check("b_valid", 64'(b_valid), 64'd1);
    rs = b_resp; id = b_id;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          output logic [1:0] rs, output logic [3:0] bid);
    model_write(addr, id, len, size, burst);
    send_aw(addr, id, len, size, burst);
    write_beats(int'(len) + 1);
    recv_b(rs, bid);
  endtask

  // Single compare process: R beats, stall stability, SRAM writes, B responses.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("r_valid_held", 64'(r_valid), 64'd1);
        check("r_data_held", r_data, prev_data);
      end
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) check("r_valid_unexpected", 64'(r_valid), 64'd0);
        else begin
          rbeat_t e;
          e = exp_r.pop_front();
          check("r_data", r_data, e.data);
          check("r_resp", 64'(r_resp), 64'(e.resp));
          check("r_last", 64'(r_last), 64'(e.last));
          check("r_id", 64'(r_id), 64'(e.id));
        end
      end
      prev_stall <= r_valid && !r_ready;
      prev_data  <= r_data;
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) check("w_ready_unexpected", 64'(w_ready), 64'd0);
        else begin
          wbeat_t e;
          e = exp_w.pop_front();
          check("sram_en_wr", 64'(sram_en), 64'd1);
          check("sram_we", 64'(sram_we), 64'(e.we));
          check("sram_addr_wr", 64'(sram_addr), 64'(e.idx));
          check("sram_wdata", sram_wdata, e.data);
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) check("b_valid_unexpected", 64'(b_valid), 64'd0);
        else begin
          bresp_t e;
          e = exp_b.pop_front();
          check("b_resp", 64'(b_resp), 64'(e.resp));
          check("b_id", 64'(b_id), 64'(e.id));
        end
      end
      if (no_sram) check("sram_en_on_err", 64'(sram_en), 64'd0);
    end
  end

  initial begin
    int          first, t;
    logic [63:0] d;
    logic [1:0]  rs;
    logic [3:0]  id;

    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; r_ready = 0; b_ready = 0;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    preload(16'h0010, 64'h1122334455667788);
    preload(16'h0001, 64'h0123456789ABCDEF);
    for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), 64'hA000_0000_0000_0000 + 64'(i * 16'h1111));

    // Reset values
    #1;
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_sram_en", 64'(sram_en), 64'd0);
    check("rst_sram_we", 64'(sram_we), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_r_id", 64'(r_id), 64'd0);
    check("rst_b_resp", 64'(b_resp), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_ar_ready", 64'(ar_ready), 64'd1);
    check("idle_aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;

    // 1: single beat, latency 3
    send_ar(32'h80, 4'd5, 8'd0, 3'd3, 2'b01);
    recv_r(1, -1, 0, first, d, rs, id);
    check("t1_latency", 64'(first), 64'd3);
    check("t1_data", d, 64'h1122334455667788);
    check("t1_id", 64'(id), 64'd5);

    // 2: INCR 4 beats, beat 1 stalled 2 cycles
    send_ar(32'h100, 4'd2, 8'd3, 3'd3, 2'b01);
    recv_r(4, 1, 2, first, d, rs, id);
    check("t2_last_data", d, 64'hA000_0000_0000_3333);

    // 3: partial-strobe write then read back
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F; wl[0] = 1'b1;
    do_write(32'h08, 4'd7, 8'd0, 3'd3, 2'b01, rs, id);
    check("t3_b_resp", 64'(rs), 64'd0);
    check("t3_b_id", 64'(id), 64'd7);
    send_ar(32'h08, 4'd3, 8'd0, 3'd3, 2'b01);
    recv_r(1, -1, 0, first, d, rs, id);
    check("t3_readback", d, 64'h01234567FFFFFFFF);

    // 4: AR and AW together; read first, AW right after return to IDLE
    wd[0] = 64'hA5A5_5A5A_0F0F_F0F0; ws[0] = 8'hFF; wl[0] = 1'b1;
    aw_addr = 32'h40; aw_id = 4'd2; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01;
    ar_addr = 32'h80; ar_id = 4'd1; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
    model_read(32'h80, 4'd1, 8'd0, 3'd3, 2'b01);
    ar_valid = 1'b1; aw_valid = 1'b1;
    @(negedge clk);
    check("t4_ar_ready", 64'(ar_ready), 64'd1);
    check("t4_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    recv_r(1, -1, 0, first, d, rs, id);
    model_write(32'h40, 4'd2, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    check("t4_aw_ready_after", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    write_beats(1);
    recv_b(rs, id);
    check("t4_b_id", 64'(id), 64'd2);

    // 5: illegal size -> SLVERR, zero data, no SRAM access
    no_sram = 1'b1;
    send_ar(32'h200, 4'd4, 8'd1, 3'd4, 2'b01);
    recv_r(2, -1, 0, first, d, rs, id);
    no_sram = 1'b0;
    check("t5_resp", 64'(rs), 64'd2);
    check("t5_data", d, 64'd0);

    // FIXED burst and address aliasing
    send_ar(32'h80, 4'd6, 8'd1, 3'd3, 2'b00);
    recv_r(2, -1, 0, first, d, rs, id);
    check("fixed_data", d, 64'h1122334455667788);
    send_ar(32'h0008_0080, 4'd8, 8'd0, 3'd3, 2'b01);
    recv_r(1, -1, 0, first, d, rs, id);
    check("alias_data", d, 64'h1122334455667788);

    // 6a: early w_last -> beat count still governs, SLVERR
    for (int i = 0; i < 3; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    wl[0] = 1'b1; wl[1] = 1'b0; wl[2] = 1'b1;
    do_write(32'h300, 4'd9, 8'd2, 3'd3, 2'b01, rs, id);
    check("t6_b_resp", 64'(rs), 64'd2);
    check("t6_b_id", 64'(id), 64'd9);

    // 6b: reset mid-read
    send_ar(32'h100, 4'd3, 8'd3, 3'd3, 2'b01);
    t = 0;
    do begin @(negedge clk); t++; end while (!r_valid && t < 20);
    check("t6_r_valid_before", 64'(r_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_r_valid_rst", 64'(r_valid), 64'd0);
    check("t6_ar_ready_rst", 64'(ar_ready), 64'd0);
    exp_r.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    r_ready = 1'b1;
    @(negedge clk);
    check("t6_idle_after", 64'(ar_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t6_no_r_valid", 64'(r_valid), 64'd0);
      check("t6_no_sram_en", 64'(sram_en), 64'd0);
      @(negedge clk);
    end
    r_ready = 1'b0;
    @(posedge clk); #1;
    send_ar(32'h80, 4'd4, 8'd0, 3'd3, 2'b01);
    recv_r(1, -1, 0, first, d, rs, id);
    check("post_rst_data", d, 64'h1122334455667788);

    check("r_queue_drained", 64'(exp_r.size()), 64'd0);
    check("w_queue_drained", 64'(exp_w.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
